// File: rtl/gradient_sched_pkg.sv
// Shared types and constants for the gradient engine frame scheduler.
package gradient_pkg;

  localparam int unsigned LAYER_W  = 3;
  localparam int unsigned WIDE_DEF = 256;
  localparam int unsigned HIGN_DEF = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  // Zero pixels needed to push a frame through the engine's two line buffers.
  function automatic int unsigned flush_len(input int unsigned wide);
    return 2 * wide;
  endfunction

endpackage

// File: rtl/gradient_sched_rr_arbiter.sv
// Round-robin pick over the layer requests, plus the rotating priority pointer.
module rr_arbiter
  import gradient_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned SEL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             update,
  input  logic [SEL_W-1:0] upd_idx,
  output logic [SEL_W-1:0] pick_c,
  output logic             any_c
);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] j_c;
  int               idx;

  // Pointer holds the last served layer; reset value makes layer 0 win first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= SEL_W'(N_REQ - 1);
    end else if (update) begin
      ptr <= upd_idx;
    end
  end

  // Scan from farthest to nearest so the first requester after ptr wins.
  always_comb begin
    pick_c = '0;
    any_c  = 1'b0;
    idx    = 0;
    j_c    = '0;
    for (int i = int'(N_REQ); i >= 1; i--) begin
      idx = int'(ptr) + i;
      if (idx >= int'(N_REQ)) begin
        idx = idx - int'(N_REQ);
      end
      j_c = SEL_W'(idx);
      if (req[j_c]) begin
        pick_c = j_c;
        any_c  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gradient_sched.sv
// Frame scheduler time-sharing one Sobel/CORDIC gradient engine between pyramid layers.
// Optional idle-pixel watchdog enabled by defining GRADIENT_SCHED_TIMEOUT_EN.
module gradient_sched
  import gradient_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned WIDE      = WIDE_DEF,
  parameter int unsigned HIGN      = HIGN_DEF,
  parameter int unsigned DW        = 8,
  parameter int unsigned CNT_DW    = 16,
  parameter int unsigned DRAIN_CYC = 32,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  output logic [N_REQ-1:0]    gnt,
  input  logic [N_REQ-1:0]    pix_valid,
  input  logic [N_REQ*DW-1:0] pix_data,
  output logic                eng_valid,
  output logic [DW-1:0]       eng_data,
  output logic [LAYER_W-1:0]  cur_layer,
  output logic                busy,
  output logic                frame_done,
  output logic                aborted
);

  localparam int unsigned SEL_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned FLUSH_LEN = flush_len(WIDE);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT == 0) begin : g_cfg_bad
    $error("gradient_sched: unsupported parameter set");
  end

  state_t              state, state_nxt;
  logic [SEL_W-1:0]    sel, sel_nxt;
  logic [CNT_DW-1:0]   col, col_nxt;
  logic [CNT_DW-1:0]   row, row_nxt;
  logic [CNT_DW-1:0]   ph, ph_nxt;
  logic [N_REQ-1:0]    gnt_nxt;
  logic                ev_nxt;
  logic [DW-1:0]       ed_nxt;
  logic [LAYER_W-1:0]  cl_nxt;
  logic                fd_nxt;
  logic                ab_nxt;
  logic                busy_nxt;
  logic [SEL_W-1:0]    pick_c;
  logic                any_c;
  logic                rr_upd_c;
  logic                pv_c;
  logic [DW-1:0]       px_c;
  logic [DW-1:0]       lane [N_REQ];
`ifdef GRADIENT_SCHED_TIMEOUT_EN
  logic [CNT_DW-1:0]   idle, idle_nxt;
  logic                abort_flag, abort_flag_nxt;
`endif

  rr_arbiter #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .update  (rr_upd_c),
    .upd_idx (sel),
    .pick_c  (pick_c),
    .any_c   (any_c)
  );

  // Pixel lane of the selected layer.
  always_comb begin
    for (int k = 0; k < int'(N_REQ); k++) begin
      lane[k] = pix_data[k*DW +: DW];
    end
    pv_c = pix_valid[sel];
    px_c = lane[sel];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      sel        <= '0;
      col        <= '0;
      row        <= '0;
      ph         <= '0;
      gnt        <= '0;
      eng_valid  <= 1'b0;
      eng_data   <= '0;
      cur_layer  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state      <= state_nxt;
      sel        <= sel_nxt;
      col        <= col_nxt;
      row        <= row_nxt;
      ph         <= ph_nxt;
      gnt        <= gnt_nxt;
      eng_valid  <= ev_nxt;
      eng_data   <= ed_nxt;
      cur_layer  <= cl_nxt;
      busy       <= busy_nxt;
      frame_done <= fd_nxt;
      aborted    <= ab_nxt;
    end
  end

`ifdef GRADIENT_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle       <= '0;
      abort_flag <= 1'b0;
    end else begin
      idle       <= idle_nxt;
      abort_flag <= abort_flag_nxt;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    col_nxt   = col;
    row_nxt   = row;
    ph_nxt    = ph;
    gnt_nxt   = '0;
    ev_nxt    = 1'b0;
    ed_nxt    = '0;
    cl_nxt    = cur_layer;
    fd_nxt    = 1'b0;
    ab_nxt    = 1'b0;
    rr_upd_c  = 1'b0;
`ifdef GRADIENT_SCHED_TIMEOUT_EN
    idle_nxt       = idle;
    abort_flag_nxt = abort_flag;
`endif
    case (state)
      ST_IDLE: begin
        if (any_c) begin
          sel_nxt   = pick_c;
          cl_nxt    = LAYER_W'(pick_c);
          gnt_nxt   = N_REQ'(1) << pick_c;
          col_nxt   = '0;
          row_nxt   = '0;
          ph_nxt    = '0;
          state_nxt = ST_STREAM;
`ifdef GRADIENT_SCHED_TIMEOUT_EN
          idle_nxt       = '0;
          abort_flag_nxt = 1'b0;
`endif
        end
      end
      ST_STREAM: begin
        gnt_nxt = gnt;
        if (pv_c) begin
          ev_nxt = 1'b1;
          ed_nxt = px_c;
`ifdef GRADIENT_SCHED_TIMEOUT_EN
          idle_nxt = '0;
`endif
          if (col == CNT_DW'(WIDE - 1)) begin
            col_nxt = '0;
            if (row == CNT_DW'(HIGN - 1)) begin
              row_nxt   = '0;
              ph_nxt    = '0;
              gnt_nxt   = '0;
              state_nxt = ST_FLUSH;
            end else begin
              row_nxt = row + CNT_DW'(1);
            end
          end else begin
            col_nxt = col + CNT_DW'(1);
          end
        end
`ifdef GRADIENT_SCHED_TIMEOUT_EN
        else begin
          // Watchdog fires after TIMEOUT consecutive idle cycles.
          idle_nxt = idle + CNT_DW'(1);
          if (idle_nxt == CNT_DW'(TIMEOUT)) begin
            ph_nxt         = '0;
            gnt_nxt        = '0;
            abort_flag_nxt = 1'b1;
            state_nxt      = ST_FLUSH;
          end
        end
`endif
      end
      ST_FLUSH: begin
        ev_nxt = 1'b1;
        ed_nxt = '0;
        if (ph == CNT_DW'(FLUSH_LEN - 1)) begin
          ph_nxt    = '0;
          state_nxt = ST_DRAIN;
        end else begin
          ph_nxt = ph + CNT_DW'(1);
        end
      end
      ST_DRAIN: begin
        // Extra terminal cycle: engine side sees DRAIN_CYC idle cycles before frame_done.
        if (ph == CNT_DW'(DRAIN_CYC)) begin
          ph_nxt    = '0;
          fd_nxt    = 1'b1;
          rr_upd_c  = 1'b1;
          state_nxt = ST_IDLE;
`ifdef GRADIENT_SCHED_TIMEOUT_EN
          ab_nxt = abort_flag;
`endif
        end else begin
          ph_nxt = ph + CNT_DW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_gradient_sched.sv
// Randomized self-checking bench for gradient_sched against a frame-level timing model.
module tb_gradient_sched;

  localparam int unsigned N    = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned H    = 8;
  localparam int unsigned DW   = 8;
  localparam int unsigned DR   = 4;
  localparam int unsigned TO   = 16;
  localparam int unsigned PW   = N * DW;
  localparam int          NPIX = W * H;
  localparam int          FL   = 2 * W;
`ifdef GRADIENT_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [N-1:0]  pix_valid;
  logic [PW-1:0] pix_data;
  logic          eng_valid;
  logic [DW-1:0] eng_data;
  logic [2:0]    cur_layer;
  logic          busy;
  logic          frame_done;
  logic          aborted;

  int n_chk = 0;
  int n_bad = 0;
  int last_l = N - 1;

  gradient_sched #(
    .N_REQ(N), .WIDE(W), .HIGN(H), .DW(DW), .CNT_DW(16), .DRAIN_CYC(DR), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .pix_valid(pix_valid), .pix_data(pix_data),
    .eng_valid(eng_valid), .eng_data(eng_data), .cur_layer(cur_layer), .busy(busy),
    .frame_done(frame_done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Round-robin reference: first requester strictly after the last served layer.
  function automatic int pick_layer(input logic [N-1:0] rq);
    int j;
    pick_layer = -1;
    for (int i = 1; i <= int'(N); i++) begin
      j = (last_l + i) % int'(N);
      if (pick_layer < 0 && rq[j]) pick_layer = j;
    end
  endfunction

  // Random traffic on every lane, then the chosen lane overridden.
  task automatic drive(input int l, input logic v, input logic [DW-1:0] d);
    pix_valid = N'($urandom);
    pix_data  = PW'($urandom);
    pix_valid[l] = v;
    pix_data[l*DW +: DW] = d;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_eng_valid"}, 32'(eng_valid), 0);
    chk({tag, "_eng_data"}, 32'(eng_data), 0);
    chk({tag, "_cur_layer"}, 32'(cur_layer), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_aborted"}, 32'(aborted), 0);
  endtask

  // One frame: request, stream n_pix pixels every gap cycles, then follow flush/drain/done.
  task automatic run_frame(input logic [N-1:0] rq, input int gap, input int n_pix,
                           input bit hold, input int want_slot);
    int l, waited, c, sent, idle_run, q, done_c;
    bit acc, timed_out;
    logic [DW-1:0] d;
    l = pick_layer(rq);
    req = rq;
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (gnt == '0 && waited < 8);
    chk("grant_latency", waited, 1);
    chk("grant_onehot", 32'(gnt), 1 << l);
    chk("grant_layer", 32'(cur_layer), l);
    chk("grant_busy", 32'(busy), 1);
    if (!hold) req = '0;
    c = 0; sent = 0; idle_run = 0; q = 1 << 30; timed_out = 1'b0;
    done_c = q + FL + int'(DR) + 1;
    while (c < 3000) begin
      acc = 1'b0;
      d = DW'($urandom);
      if (c < q) begin
        if (sent < n_pix && (c % gap) == 0) begin
          acc = 1'b1;
          sent++;
          idle_run = 0;
          if (sent == NPIX) q = c + 1;
        end else begin
          idle_run++;
          if (TO_EN && idle_run == int'(TO)) begin
            q = c + 1;
            timed_out = 1'b1;
          end
        end
        drive(l, acc, d);
      end else begin
        drive(l, 1'($urandom), d);
      end
      done_c = q + FL + int'(DR) + 1;
      @(posedge clk); #1;
      c++;
      chk("gnt", 32'(gnt), (c < q) ? (1 << l) : 0);
      if (c - 1 < q) begin
        chk("stream_valid", 32'(eng_valid), 32'(acc));
        if (acc) chk("stream_data", 32'(eng_data), 32'(d));
      end else if (c - 1 < q + FL) begin
        chk("flush_valid", 32'(eng_valid), 1);
        chk("flush_data", 32'(eng_data), 0);
      end else begin
        chk("drain_valid", 32'(eng_valid), 0);
      end
      chk("frame_done", 32'(frame_done), 32'(c == done_c));
      chk("busy", 32'(busy), 32'(c < done_c));
      chk("aborted", 32'(aborted), 32'(c == done_c && timed_out));
      if (c == done_c) begin
        chk("done_layer", 32'(cur_layer), l);
        break;
      end
    end
    if (c >= 3000) chk("frame_never_done", 32'(frame_done), 1);
    if (want_slot > 0) chk("slot_length", c, want_slot);
    last_l = l;
  endtask

  initial begin
    int waited;
    rst = 1'b0; req = '0; pix_valid = '0; pix_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    run_frame(4'b0100, 1, NPIX, 1'b0, 85);
    for (int f = 0; f < 4; f++) run_frame(4'b1111, 1, NPIX, 1'b1, 0);
    req = '0;
    run_frame(4'b0110, 3, NPIX, 1'b0, 0);
    for (int f = 0; f < 4; f++)
      run_frame(N'($urandom_range(1, 15)), int'($urandom_range(1, 3)), NPIX, 1'b0, 0);
`ifdef GRADIENT_SCHED_TIMEOUT_EN
    run_frame(4'b1000, 1, 10, 1'b0, 0);
`endif

    // Reset in the middle of FLUSH: frame discarded and pointer back to its reset value.
    run_frame(4'b0001, 1, NPIX, 1'b0, 0);
    req = 4'b0010;
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (gnt == '0 && waited < 8);
    chk("rst_frame_gnt", 32'(gnt), 32'b0010);
    req = '0;
    repeat (66) begin
      drive(1, 1'b1, DW'($urandom));
      @(posedge clk); #1;
    end
    chk("pre_reset_flush_valid", 32'(eng_valid), 1);
    chk("pre_reset_gnt", 32'(gnt), 0);
    pix_valid = '0;
    #2 rst = 1'b0;
    #1 check_idle_outputs("async_reset");
    @(posedge clk); #1;
    check_idle_outputs("held_reset");
    rst = 1'b1;
    last_l = N - 1;
    @(posedge clk); #1;
    run_frame(4'b1111, 1, NPIX, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1);
  end

endmodule
